// File: rtl/riscv_run_ctrl_pkg.sv
// Shared types and constants for the RISC-V run controller.
//   run_state_e      : sequencer states
//   DEF_TOHOST_ADDR  : default halt-mailbox address
//   HALT_BIT         : bit of the to-host write that marks a halt
//   EXIT_LSB         : lowest bit of the exit-code field (field runs up to DATA_W-1)
package riscv_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_STAGGER,
    ST_RUN,
    ST_DONE
  } run_state_e;

  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;
  localparam int unsigned HALT_BIT        = 0;
  localparam int unsigned EXIT_LSB        = 1;

endpackage

// File: rtl/riscv_reset_stagger.sv
// Per-core reset release sequencer.
// A launch pulse loads one down-counter per core with RST_CYCLES + i*STAGGER;
// core i leaves reset when its counter reaches terminal count.
//   clk, reset      : clock, synchronous active-high reset
//   launch          : one-cycle pulse on the edge that enters HOLD
//   hold_all        : force every core back into reset and cancel counting
//   core_rst        : active-high reset per core (registered)
//   first_release   : core 0 leaves reset on the next edge
//   last_release    : core NUM_CORES-1 leaves reset on the next edge
module riscv_reset_stagger #(
  parameter int unsigned NUM_CORES  = 1,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned STAGGER    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 launch,
  input  logic                 hold_all,
  output logic [NUM_CORES-1:0] core_rst,
  output logic                 first_release,
  output logic                 last_release
);

  localparam int unsigned MAX_DLY = RST_CYCLES + (NUM_CORES - 1) * STAGGER;
  localparam int unsigned CW      = $clog2(MAX_DLY + 1);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    localparam logic [CW-1:0] REL_DLY = CW'(RST_CYCLES + i * STAGGER);

    logic [CW-1:0] dly_cnt;
    logic          rst_q;

    always_ff @(posedge clk) begin
      if (reset || hold_all) begin
        dly_cnt <= '0;
        rst_q   <= 1'b1;
      end else if (launch) begin
        dly_cnt <= REL_DLY;
        rst_q   <= 1'b1;
      end else if (dly_cnt != '0) begin
        dly_cnt <= dly_cnt - 1'b1;
        if (dly_cnt == CW'(1)) rst_q <= 1'b0;
      end
    end

    assign core_rst[i] = rst_q;

    if (i == 0) begin : g_first
      assign first_release = (dly_cnt == CW'(1));
    end
    if (i == NUM_CORES - 1) begin : g_last
      assign last_release = (dly_cnt == CW'(1));
    end
  end

endmodule

// File: rtl/riscv_run_controller.sv
// Run controller for RISC-V multicycle cores: sequences core resets, snoops
// the data-memory write bus for a to-host halt write, counts run cycles and
// reports pass / fail / timeout (and hang with the watchdog build).
// Optional feature macro: RUN_CTRL_WDOG_EN enables the idle-bus watchdog.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   start                         : launch / relaunch request (IDLE or DONE only)
//   mon_we, mon_addr, mon_wdata   : snooped core-0 data-memory write bus
//   core_rst                      : active-high reset per core
//   busy                          : HOLD, STAGGER or RUN
//   done, pass, fail, timeout, hang, exit_code : sticky run result
//   run_cycles                    : cycles spent in RUN (saturating)
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | cores in reset, waiting for start
// HOLD    | all cores held in reset for RST_CYCLES
// STAGGER | cores released one by one, STAGGER apart
// RUN     | cores running, bus snooped, cycles counted
// DONE    | cores in reset, result held until start
module riscv_run_controller
  import riscv_run_ctrl_pkg::*;
#(
  parameter int unsigned       NUM_CORES   = 1,
  parameter int unsigned       RST_CYCLES  = 4,
  parameter int unsigned       STAGGER     = 0,
  parameter int unsigned       MAX_CYCLES  = 1000,
  parameter int unsigned       WDOG_CYCLES = 256,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(DEF_TOHOST_ADDR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mon_we,
  input  logic [ADDR_W-1:0]    mon_addr,
  input  logic [DATA_W-1:0]    mon_wdata,
  output logic [NUM_CORES-1:0] core_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic                 hang,
  output logic [DATA_W-2:0]    exit_code,
  output logic [CNT_W-1:0]     run_cycles
);

  localparam bit               USE_STAGGER    = (NUM_CORES > 1) && (STAGGER > 0);
  localparam logic [CNT_W-1:0] LAST_RUN_CYCLE = CNT_W'(MAX_CYCLES - 1);

  run_state_e        state, next_state;
  logic              launch, hold_all;
  logic              first_release, last_release;
  logic              halt_hit, tmo_hit, hang_hit;
  logic [DATA_W-2:0] halt_code;

  assign halt_code = mon_wdata[DATA_W-1:EXIT_LSB];
  assign halt_hit  = mon_we && (mon_addr == TOHOST_ADDR) && mon_wdata[HALT_BIT];
  assign tmo_hit   = (run_cycles == LAST_RUN_CYCLE);

`ifdef RUN_CTRL_WDOG_EN
  localparam int unsigned   WDW       = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LOAD = WDW'(WDOG_CYCLES);

  // Remaining idle cycles; reloaded by any bus write and while not running,
  // so the first RUN cycle already counts as idle.
  logic [WDW-1:0] wdog_left;

  always_ff @(posedge clk) begin
    if (reset || (state != ST_RUN) || mon_we) begin
      wdog_left <= WDOG_LOAD;
    end else if (wdog_left != '0) begin
      wdog_left <= wdog_left - 1'b1;
    end
  end

  assign hang_hit = (state == ST_RUN) && !mon_we && (wdog_left == WDW'(1));
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES != 0);
  assign hang_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_HOLD;
      ST_HOLD:          if (first_release) next_state = USE_STAGGER ? ST_STAGGER : ST_RUN;
      ST_STAGGER:       if (last_release) next_state = ST_RUN;
      ST_RUN:           if (halt_hit || tmo_hit || hang_hit) next_state = ST_DONE;
      default:          next_state = ST_IDLE;
    endcase
  end

  assign launch   = start && ((state == ST_IDLE) || (state == ST_DONE));
  // Forcing resets on the transition edge puts core_rst high in the same
  // cycle that done becomes visible.
  assign hold_all = (next_state == ST_IDLE) || (next_state == ST_DONE);

  riscv_reset_stagger #(
    .NUM_CORES  (NUM_CORES),
    .RST_CYCLES (RST_CYCLES),
    .STAGGER    (STAGGER)
  ) u_stagger (
    .clk           (clk),
    .reset         (reset),
    .launch        (launch),
    .hold_all      (hold_all),
    .core_rst      (core_rst),
    .first_release (first_release),
    .last_release  (last_release)
  );

  // Result flags; priority halt > timeout > hang. run_cycles only advances
  // when RUN continues, so it freezes at the value of the finishing cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      hang       <= 1'b0;
      exit_code  <= '0;
      run_cycles <= '0;
    end else begin
      busy <= (next_state == ST_HOLD) || (next_state == ST_STAGGER) || (next_state == ST_RUN);
      if (launch) begin
        done       <= 1'b0;
        pass       <= 1'b0;
        fail       <= 1'b0;
        timeout    <= 1'b0;
        hang       <= 1'b0;
        exit_code  <= '0;
        run_cycles <= '0;
      end else if (state == ST_RUN) begin
        if (halt_hit) begin
          done      <= 1'b1;
          exit_code <= halt_code;
          pass      <= (halt_code == '0);
          fail      <= (halt_code != '0);
        end else if (tmo_hit) begin
          done    <= 1'b1;
          timeout <= 1'b1;
          fail    <= 1'b1;
        end else if (hang_hit) begin
          done <= 1'b1;
          hang <= 1'b1;
          fail <= 1'b1;
        end else if (run_cycles != '1) begin
          run_cycles <= run_cycles + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_run_controller.sv
// Directed bench: dut (1 core, RST_CYCLES=4, MAX_CYCLES=50, WDOG_CYCLES=16)
// and dut3 (3 cores, STAGGER=2). Both share the reset and snoop bus.
module tb_riscv_run_controller;

  logic        clk = 1'b0;
  logic        reset, start, start3;
  logic        mon_we;
  logic [31:0] mon_addr, mon_wdata;

  logic [0:0]  core_rst;
  logic        busy, done, pass, fail, timeout, hang;
  logic [30:0] exit_code;
  logic [31:0] run_cycles;

  logic [2:0]  core_rst3;
  logic        busy3, done3, pass3, fail3, timeout3, hang3;
  logic [30:0] exit_code3;
  logic [31:0] run_cycles3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_run_controller #(
    .NUM_CORES(1), .RST_CYCLES(4), .STAGGER(0), .MAX_CYCLES(50), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mon_we(mon_we), .mon_addr(mon_addr),
    .mon_wdata(mon_wdata), .core_rst(core_rst), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .hang(hang), .exit_code(exit_code), .run_cycles(run_cycles)
  );

  riscv_run_controller #(
    .NUM_CORES(3), .RST_CYCLES(4), .STAGGER(2), .MAX_CYCLES(50)
  ) dut3 (
    .clk(clk), .reset(reset), .start(start3), .mon_we(mon_we), .mon_addr(mon_addr),
    .mon_wdata(mon_wdata), .core_rst(core_rst3), .busy(busy3), .done(done3), .pass(pass3),
    .fail(fail3), .timeout(timeout3), .hang(hang3), .exit_code(exit_code3),
    .run_cycles(run_cycles3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start pulse then RST_CYCLES edges: first RUN cycle afterwards
  task automatic enter_run();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
  endtask

  // RUN for n cycles with occasional non-halting writes
  task automatic run_for(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 3) begin
        mon_we    = 1'b1;
        mon_addr  = (i % 16 == 3) ? 32'h1000 : 32'h2000;
        mon_wdata = (i % 16 == 3) ? 32'h2 : 32'h1;
      end else begin
        mon_we = 1'b0;
      end
      step();
    end
    mon_we = 1'b0;
  endtask

  task automatic do_halt(input logic [31:0] data);
    mon_we    = 1'b1;
    mon_addr  = 32'h1000;
    mon_wdata = data;
    step();
    mon_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_vec++; if (core_rst !== 1'b1)   begin n_err++; $display("FAIL rst_core_rst got %b want 1", core_rst); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if ({done, pass, fail, timeout, hang} !== 5'b0) begin n_err++; $display("FAIL rst_flags got %b want 00000", {done, pass, fail, timeout, hang}); end
    n_vec++; if (exit_code !== 31'd0) begin n_err++; $display("FAIL rst_exit got %0d want 0", exit_code); end
    n_vec++; if (run_cycles !== 32'd0) begin n_err++; $display("FAIL rst_cycles got %0d want 0", run_cycles); end
    n_vec++; if (core_rst3 !== 3'b111) begin n_err++; $display("FAIL rst_core_rst3 got %b want 111", core_rst3); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_stagger();
    logic [2:0] exp_rst [10];
    exp_rst = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000};
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_vec++; if (core_rst3 !== exp_rst[k]) begin n_err++; $display("FAIL stagger_rst k=%0d got %b want %b", k, core_rst3, exp_rst[k]); end
      n_vec++; if (busy3 !== 1'b1) begin n_err++; $display("FAIL stagger_busy k=%0d got %b want 1", k, busy3); end
      if (k == 8) begin
        n_vec++; if (run_cycles3 !== 32'd0) begin n_err++; $display("FAIL stagger_run_entry got %0d want 0", run_cycles3); end
      end
      if (k == 9) begin
        n_vec++; if (run_cycles3 !== 32'd1) begin n_err++; $display("FAIL stagger_run_count got %0d want 1", run_cycles3); end
      end
      step();
    end
    do_halt(32'h1);
    n_vec++; if ({done3, pass3, fail3} !== 3'b110) begin n_err++; $display("FAIL stagger_halt got %b want 110", {done3, pass3, fail3}); end
    n_vec++; if (core_rst3 !== 3'b111) begin n_err++; $display("FAIL stagger_rst_after got %b want 111", core_rst3); end
    n_vec++; if (run_cycles3 !== 32'd2) begin n_err++; $display("FAIL stagger_cycles got %0d want 2", run_cycles3); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_snoop got %b want 0", done); end
  endtask

  task automatic test_halt_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL hold_busy got %b want 1", busy); end
    n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL hold_rst got %b want 1", core_rst); end
    do_halt(32'h1);
    n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL hold_snoop got %b want 0", done); end
    step();
    step();
    n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL hold_last_rst got %b want 1", core_rst); end
    step();
    n_vec++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL run_rst got %b want 0", core_rst); end
    n_vec++; if (run_cycles !== 32'd0) begin n_err++; $display("FAIL run_entry_cycles got %0d want 0", run_cycles); end
    run_for(20);
    n_vec++; if (run_cycles !== 32'd20) begin n_err++; $display("FAIL run_count got %0d want 20", run_cycles); end
    n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL ignored_writes got %b want 0", done); end
    do_halt(32'h1);
    n_vec++; if ({done, pass, fail, timeout} !== 4'b1100) begin n_err++; $display("FAIL pass_flags got %b want 1100", {done, pass, fail, timeout}); end
    n_vec++; if (exit_code !== 31'd0) begin n_err++; $display("FAIL pass_exit got %0d want 0", exit_code); end
    n_vec++; if ({core_rst, busy} !== 2'b10) begin n_err++; $display("FAIL pass_rst_busy got %b want 10", {core_rst, busy}); end
    n_vec++; if (run_cycles !== 32'd20) begin n_err++; $display("FAIL pass_cycles got %0d want 20", run_cycles); end
    step();
    n_vec++; if ({done, run_cycles} !== {1'b1, 32'd20}) begin n_err++; $display("FAIL done_sticky got %b/%0d want 1/20", done, run_cycles); end
  endtask

  task automatic test_halt_fail();
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if ({done, pass, run_cycles} !== {2'b00, 32'd0}) begin n_err++; $display("FAIL relaunch_clear got %b%b/%0d want 00/0", done, pass, run_cycles); end
    repeat (4) step();
    n_vec++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL relaunch_run got %b want 0", core_rst); end
    run_for(5);
    do_halt(32'h7);
    n_vec++; if ({done, pass, fail} !== 3'b101) begin n_err++; $display("FAIL fail_flags got %b want 101", {done, pass, fail}); end
    n_vec++; if (exit_code !== 31'd3) begin n_err++; $display("FAIL fail_exit got %0d want 3", exit_code); end
    n_vec++; if (run_cycles !== 32'd5) begin n_err++; $display("FAIL fail_cycles got %0d want 5", run_cycles); end
  endtask

  task automatic test_timeout();
    enter_run();
    run_for(49);
    n_vec++; if ({done, run_cycles} !== {1'b0, 32'd49}) begin n_err++; $display("FAIL pre_timeout got %b/%0d want 0/49", done, run_cycles); end
    step();
    n_vec++; if ({done, timeout, fail, pass} !== 4'b1110) begin n_err++; $display("FAIL timeout_flags got %b want 1110", {done, timeout, fail, pass}); end
    n_vec++; if (run_cycles !== 32'd49) begin n_err++; $display("FAIL timeout_cycles got %0d want 49", run_cycles); end
    n_vec++; if ({core_rst, busy} !== 2'b10) begin n_err++; $display("FAIL timeout_rst_busy got %b want 10", {core_rst, busy}); end
  endtask

  task automatic test_halt_beats_timeout();
    enter_run();
    run_for(49);
    do_halt(32'h1);
    n_vec++; if ({done, pass, fail, timeout} !== 4'b1100) begin n_err++; $display("FAIL race_flags got %b want 1100", {done, pass, fail, timeout}); end
    n_vec++; if (run_cycles !== 32'd49) begin n_err++; $display("FAIL race_cycles got %0d want 49", run_cycles); end
  endtask

  task automatic test_mid_run_reset();
    enter_run();
    run_for(10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if ({core_rst, busy, done} !== 3'b100) begin n_err++; $display("FAIL midrst_state got %b want 100", {core_rst, busy, done}); end
    n_vec++; if (run_cycles !== 32'd0) begin n_err++; $display("FAIL midrst_cycles got %0d want 0", run_cycles); end
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle got %b want 0", busy); end
    enter_run();
    n_vec++; if ({core_rst, run_cycles} !== {1'b0, 32'd0}) begin n_err++; $display("FAIL midrst_relaunch got %b/%0d want 0/0", core_rst, run_cycles); end
    run_for(5);
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if ({core_rst, busy, run_cycles} !== {2'b01, 32'd6}) begin n_err++; $display("FAIL busy_start got %b%b/%0d want 01/6", core_rst, busy, run_cycles); end
    do_halt(32'h1);
    n_vec++; if ({done, pass, run_cycles} !== {2'b11, 32'd6}) begin n_err++; $display("FAIL busy_start_halt got %b%b/%0d want 11/6", done, pass, run_cycles); end
  endtask

  task automatic test_watchdog();
    enter_run();
    mon_we    = 1'b1;
    mon_addr  = 32'h2000;
    mon_wdata = 32'h11;
    repeat (5) step();
    mon_we = 1'b0;
    repeat (15) step();
    n_vec++; if ({done, run_cycles} !== {1'b0, 32'd20}) begin n_err++; $display("FAIL wdog_pre got %b/%0d want 0/20", done, run_cycles); end
    step();
`ifdef RUN_CTRL_WDOG_EN
    n_vec++; if ({done, hang, fail, timeout} !== 4'b1110) begin n_err++; $display("FAIL wdog_hang got %b want 1110", {done, hang, fail, timeout}); end
    n_vec++; if (run_cycles !== 32'd20) begin n_err++; $display("FAIL wdog_cycles got %0d want 20", run_cycles); end
`else
    n_vec++; if ({done, hang} !== 2'b00) begin n_err++; $display("FAIL nowdog_run got %b want 00", {done, hang}); end
    repeat (28) step();
    n_vec++; if ({done, run_cycles} !== {1'b0, 32'd49}) begin n_err++; $display("FAIL nowdog_pre got %b/%0d want 0/49", done, run_cycles); end
    step();
    n_vec++; if ({done, timeout, fail, hang} !== 4'b1110) begin n_err++; $display("FAIL nowdog_timeout got %b want 1110", {done, timeout, fail, hang}); end
`endif
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    start3    = 1'b0;
    mon_we    = 1'b0;
    mon_addr  = 32'h0;
    mon_wdata = 32'h0;
    test_reset();
    test_stagger();
    test_halt_pass();
    test_halt_fail();
    test_timeout();
    test_halt_beats_timeout();
    test_mid_run_reset();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_run_controller.md
# riscv_run_controller

Parametrised run controller for the RISC-V multicycle core(s): sequences core reset, snoops the data-memory write bus for a to-host halt write, counts run cycles, and reports pass/fail/timeout. It sits between the top-level clock/reset and one or more core instances, replacing fixed-delay reset and run-length control with a cycle-exact, synthesizable sequencer usable both in benches and on FPGA.

## Interface

Parameters:

- NUM_CORES, 1, number of cores driven; each gets its own reset line
- RST_CYCLES, 4, cycles all core resets are held after start (≥1)
- STAGGER, 0, extra cycles between successive core releases (0 releases all together)
- MAX_CYCLES, 1000, run-cycle budget before timeout (≥2)
- WDOG_CYCLES, 256, idle-bus limit (only with watchdog macro)
- CNT_W, 32, width of cycle counter
- ADDR_W, 32, snoop address width
- DATA_W, 32, snoop data width
- TOHOST_ADDR, 32'h0000_1000, halt-mailbox address

Ports:

- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  launch/relaunch request, level sampled
- mon_we  in  1  data-memory write strobe snooped from core 0 bus
- mon_addr  in  ADDR_W  snooped write address
- mon_wdata  in  DATA_W  snooped write data
- core_rst  out  NUM_CORES  active-high reset per core
- busy  out  1  HOLD, STAGGER or RUN
- done  out  1  run finished (sticky until start/reset)
- pass  out  1  halt with exit code 0
- fail  out  1  halt with non-zero code, timeout, or hang
- timeout  out  1  MAX_CYCLES exhausted
- hang  out  1  watchdog fired (tied 0 without macro)
- exit_code  out  DATA_W-1  mon_wdata[DATA_W-1:1] of halt write
- run_cycles  out  CNT_W  cycles spent in RUN

## Operation

- States: IDLE, HOLD, STAGGER, RUN, DONE.
- reset: state IDLE, core_rst all 1, busy/done/pass/fail/timeout/hang 0, exit_code 0, run_cycles 0.
- IDLE: core_rst all 1; start=1 → HOLD, status flags and run_cycles cleared.
- HOLD: exactly RST_CYCLES cycles, all resets high → STAGGER (if NUM_CORES>1 and STAGGER>0) else RUN with all resets low.
- STAGGER: core i released RST_CYCLES + i·STAGGER cycles after HOLD entry; after core NUM_CORES-1 released → RUN.
- RUN: run_cycles increments every RUN cycle (saturates at all-ones). Halt = mon_we && mon_addr==TOHOST_ADDR && mon_wdata[0]==1 → DONE, exit_code captured, pass = (code==0), fail = !pass.
- Timeout: in RUN cycle where run_cycles == MAX_CYCLES-1 and no halt → DONE, timeout=1, fail=1.
- Halt and timeout in same cycle: halt wins, timeout stays 0.
- Writes to TOHOST_ADDR with wdata[0]=0 ignored; snoop ignored outside RUN.
- DONE: core_rst all 1, run_cycles frozen, flags held; start=1 → HOLD (relaunch, flags cleared).
- start while busy ignored.
- reset in any state, including mid-RUN: immediate return to reset values next edge.

## Timing

- start high at edge t (IDLE) → busy=1, state HOLD from t+1.
- NUM_CORES=1: core_rst falls at t+1+RST_CYCLES; first RUN cycle same cycle, run_cycles reads 0 then.
- Halt write sampled at edge e → done/pass/fail/exit_code valid from e+1, core_rst high from e+1.
- Timeout: done/timeout from MAX_CYCLES edges after RUN entry.
- All outputs registered; no combinational input-to-output path.

## Configuration

- RUN_CTRL_WDOG_EN defined: in RUN, counter clears on every mon_we; reaching WDOG_CYCLES consecutive cycles without mon_we → DONE, hang=1, fail=1. Halt and timeout take priority over hang in the same cycle.
- Undefined: no watchdog logic; hang constant 0.

## Structure

- Package riscv_run_ctrl_pkg: state enum, default TOHOST_ADDR, halt bit index (0), exit-code field bounds.
- One sub-module riscv_reset_stagger: per-core release counter producing core_rst from HOLD-entry pulse, RST_CYCLES, STAGGER, NUM_CORES.

## Test plan

- NUM_CORES=1, RST_CYCLES=4, start at cycle 10 → core_rst falls at 15, busy 11..done; write 0x1000←0x1 at RUN cycle 20 → pass=1, exit_code=0, core_rst=1 next cycle.
- Halt write 0x1000←0x7 → fail=1, pass=0, exit_code=3.
- MAX_CYCLES=50, no halt → done and timeout at RUN cycle 50, run_cycles=49; halt on cycle 49 instead → pass, timeout=0.
- NUM_CORES=3, STAGGER=2, RST_CYCLES=4 → releases at 4, 6, 8 cycles after HOLD entry; RUN entered with last release.
- reset asserted mid-RUN → all outputs at reset values next edge; start afterwards relaunches cleanly; start during RUN ignored.
- RUN_CTRL_WDOG_EN, WDOG_CYCLES=16, bus silent after 5 writes → hang=1, fail=1 on 16th idle cycle; without macro, same stimulus hits timeout.
